awg_cmd_decoder: RTL

//   Framed UART command decoder for the multi-channel AWG. Parses checksummed packets from
//   the UART receiver and writes per-channel waveform type, frequency word, amplitude and DC

---
 rtl/awg_cmd_decoder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/awg_cmd_decoder.sv
// rtl/awg_cmd_decoder.sv - framed UART command decoder writing per-channel AWG registers
module awg_cmd_decoder #(
  parameter int          NUM_CH      = 2,
  parameter int          FREQ_W      = 16,
  parameter int          AMP_W       = 10,
  parameter int          OFS_W       = 10,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               uart_data,
  input  logic                     data_valid,
  output logic [2*NUM_CH-1:0]      waveform_type,
  output logic [FREQ_W*NUM_CH-1:0] frequency,
  output logic [AMP_W*NUM_CH-1:0]  amplitude,
  output logic [OFS_W*NUM_CH-1:0]  dc_offset,
  output logic                     cmd_ok,
  output logic                     cmd_err,
  output logic                     busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DHI,
    S_DLO,
    S_CHK
  } state_t;

  state_t                     state_q;
  logic [CNT_W-1:0]           tmo_q;
  logic [7:0]                 hdr_q;
  logic [7:0]                 dhi_q;
  logic [7:0]                 dlo_q;
  logic                       ok_q;
  logic                       err_q;
  logic [2*NUM_CH-1:0]        wave_q;
  logic [FREQ_W*NUM_CH-1:0]   freq_q;
  logic [AMP_W*NUM_CH-1:0]    amp_q;
  logic [OFS_W*NUM_CH-1:0]    ofs_q;

  logic [15:0] data_d;
  logic [3:0]  ch_d;
  logic [3:0]  reg_d;
  logic        bcast_d;
  logic        addr_ok_d;
  logic        chk_ok_d;
  logic        tmo_hit_d;

  always_comb begin
    data_d    = {dhi_q, dlo_q};
    ch_d      = hdr_q[7:4];
    reg_d     = hdr_q[3:0];
    bcast_d   = (ch_d == 4'hF);
    addr_ok_d = (bcast_d || (32'(ch_d) < NUM_CH)) && (reg_d <= 4'd3);
    chk_ok_d  = ((hdr_q ^ dhi_q ^ dlo_q) == uart_data);
    tmo_hit_d = (tmo_q == CNT_W'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      hdr_q   <= '0;
      dhi_q   <= '0;
      dlo_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        wave_q[2*c +: 2]          <= 2'd0;
        freq_q[FREQ_W*c +: FREQ_W] <= FREQ_W'(1);
        amp_q[AMP_W*c +: AMP_W]    <= '1;
        ofs_q[OFS_W*c +: OFS_W]    <= OFS_W'(1) << (OFS_W - 1);
      end
    end else begin
      ok_q  <= 1'b0;
      err_q <= 1'b0;
      if (state_q == S_IDLE) begin
        tmo_q <= '0;
        if (data_valid && (uart_data == SYNC_BYTE)) state_q <= S_HDR;
      end else if (data_valid) begin
        // A byte arriving on the timeout cycle takes priority over the timeout.
        tmo_q <= '0;
        case (state_q)
          S_HDR: begin hdr_q <= uart_data; state_q <= S_DHI; end
          S_DHI: begin dhi_q <= uart_data; state_q <= S_DLO; end
          S_DLO: begin dlo_q <= uart_data; state_q <= S_CHK; end
          default: begin
            state_q <= S_IDLE;
            if (chk_ok_d && addr_ok_d) begin
              ok_q <= 1'b1;
              for (int c = 0; c < NUM_CH; c++) begin
                if (bcast_d || (ch_d == 4'(c))) begin
                  case (reg_d[1:0])
                    2'd0: wave_q[2*c +: 2]          <= data_d[1:0];
                    2'd1: freq_q[FREQ_W*c +: FREQ_W] <= data_d[FREQ_W-1:0];
                    2'd2: amp_q[AMP_W*c +: AMP_W]    <= data_d[AMP_W-1:0];
                    default: ofs_q[OFS_W*c +: OFS_W] <= data_d[OFS_W-1:0];
                  endcase
                end
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        endcase
      end else if (tmo_hit_d) begin
        state_q <= S_IDLE;
        tmo_q   <= '0;
        err_q   <= 1'b1;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  assign waveform_type = wave_q;
  assign frequency     = freq_q;
  assign amplitude     = amp_q;
  assign dc_offset     = ofs_q;
  assign cmd_ok        = ok_q;
  assign cmd_err       = err_q;
  assign busy          = (state_q != S_IDLE);

endmodule
